// File: rtl/btn_led_ctrl.sv
// Pushbutton mode controller: synchronizes and debounces BTN, steps MODE on
// each accepted release, and drives LED as off/on/slow blink/fast blink.
// Optional feature macro: BTNLED_LONGPRESS_EN (a long press forces MODE to OFF).
module btn_led_ctrl #(
    parameter int unsigned DEB_CYCLES  = 160000,
    parameter int unsigned LONG_CYCLES = 8000000,
    parameter int unsigned SLOW_HALF   = 4000000,
    parameter int unsigned FAST_HALF   = 1000000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       BTN,
    output logic       LED,
    output logic [1:0] MODE,
    output logic       PRESS
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned PH_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_e;

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic             deb_dly_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;
    mode_e            mode_q;
    mode_e            mode_d;
    logic             press_q;
    logic             press_d;
    logic [PH_W-1:0]  ph_q;
    logic [PH_W-1:0]  ph_d;
    logic             blink_q;
    logic             blink_d;
    logic             led_q;
    logic             led_d;
    logic             half_end_c;
    logic             release_c;
    logic             long_c;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= BTN;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: d follows s only after s has differed for DEB_CYCLES clocks.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                deb_d     = sync2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Debounced state, its one-cycle delay for edge detection, and the counter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Release is the cycle after d falls.
    assign release_c = deb_dly_q & ~deb_q;

`ifdef BTNLED_LONGPRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;

    // Hold time of the debounced press, saturating at the long threshold.
    always_comb begin
        hold_d = '0;
        if (deb_q) begin
            hold_d = (hold_q == HOLD_W'(LONG_CYCLES)) ? hold_q : hold_q + HOLD_W'(1);
        end
    end

    // Hold counter register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign long_c = (hold_q == HOLD_W'(LONG_CYCLES));
`else
    assign long_c = 1'b0;
`endif

    // Mode state register and release pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_q  <= MODE_OFF;
            press_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            press_q <= press_d;
        end
    end

    // Next mode: short release steps forward, long release forces OFF.
    always_comb begin
        mode_d  = mode_q;
        press_d = 1'b0;
        if (release_c) begin
            press_d = 1'b1;
            if (long_c) begin
                mode_d = MODE_OFF;
            end else begin
                case (mode_q)
                    MODE_OFF:  mode_d = MODE_ON;
                    MODE_ON:   mode_d = MODE_SLOW;
                    MODE_SLOW: mode_d = MODE_FAST;
                    MODE_FAST: mode_d = MODE_OFF;
                    default:   mode_d = MODE_OFF;
                endcase
            end
        end
    end

    // Blink phase: restarts lit on every mode change so the first half is full.
    always_comb begin
        ph_d       = ph_q + PH_W'(1);
        blink_d    = blink_q;
        half_end_c = (mode_q == MODE_FAST) ? (ph_q == PH_W'(FAST_HALF - 1))
                                           : (ph_q == PH_W'(SLOW_HALF - 1));
        if (mode_d != mode_q) begin
            ph_d    = '0;
            blink_d = 1'b1;
        end else if (half_end_c) begin
            ph_d    = '0;
            blink_d = ~blink_q;
        end
        case (mode_q)
            MODE_OFF: led_d = 1'b0;
            MODE_ON:  led_d = 1'b1;
            default:  led_d = blink_q;
        endcase
    end

    // Blink phase and LED registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ph_q    <= '0;
            blink_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            blink_q <= blink_d;
            led_q   <= led_d;
        end
    end

    assign LED   = led_q;
    assign MODE  = mode_q;
    assign PRESS = press_q;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Self-checking bench for btn_led_ctrl with small timing parameters; a
// behavioural model tracks expected MODE/PRESS/LED from button history.
module tb_btn_led_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;
    localparam int unsigned SLOW = 8;
    localparam int unsigned FAST = 2;
`ifdef BTNLED_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       BTN = 1'b0;
    logic       LED;
    logic [1:0] MODE;
    logic       PRESS;

    int checks = 0;
    int failures = 0;
    bit pat[$];

    btn_led_ctrl #(
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG),
        .SLOW_HALF  (SLOW),
        .FAST_HALF  (FAST)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .BTN    (BTN),
        .LED    (LED),
        .MODE   (MODE),
        .PRESS  (PRESS)
    );

    always #5 CLK = ~CLK;

    // Reference model: button samples arrive two clocks late; the stable level
    // flips after DEB consecutive disagreeing samples; a fall is acted on the
    // next clock; LED is a function of mode and clocks spent in that mode.
    bit         bq[$];
    bit         m_d, m_pend, m_long, s_pre;
    int         m_run, m_cyc, m_edge, m_rise, half;
    logic [1:0] exp_mode = 2'd0;
    logic [1:0] nm;
    logic       exp_led = 1'b0;
    logic       exp_press = 1'b0;

    initial begin
        forever begin
            @(posedge CLK or negedge RESET_N);
            if (!RESET_N) begin
                bq.delete();
                m_d = 0; m_pend = 0; m_long = 0;
                m_run = 0; m_cyc = 0; m_edge = 0; m_rise = 0;
                exp_mode = 2'd0; exp_led = 1'b0; exp_press = 1'b0;
            end else begin
                half = (exp_mode == 2'd3) ? FAST : SLOW;
                if (exp_mode == 2'd0)      exp_led = 1'b0;
                else if (exp_mode == 2'd1) exp_led = 1'b1;
                else                       exp_led = ((m_cyc / half) % 2) == 0;
                m_cyc++;
                exp_press = m_pend;
                if (m_pend) begin
                    nm = m_long ? 2'd0 : exp_mode + 2'd1;
                    if (nm != exp_mode) m_cyc = 0;
                    exp_mode = nm;
                end
                m_pend = 0;
                s_pre = (bq.size() >= 2) ? bq[bq.size() - 2] : 1'b0;
                if (s_pre != m_d) begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_d = s_pre;
                        m_run = 0;
                        if (m_d) m_rise = m_edge;
                        else begin
                            m_pend = 1;
                            m_long = LP_EN && ((m_edge - m_rise) >= LONG);
                        end
                    end
                end else begin
                    m_run = 0;
                end
                bq.push_back(BTN);
                if (bq.size() > 2) void'(bq.pop_front());
                m_edge++;
            end
        end
    end

    task automatic test_reset();
        RESET_N = 1'b0;
        BTN = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (MODE !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", MODE); end
        checks++;
        if (LED !== 1'b0) begin failures++; $display("FAIL reset_led got=%b exp=0", LED); end
        checks++;
        if (PRESS !== 1'b0) begin failures++; $display("FAIL reset_press got=%b exp=0", PRESS); end
        RESET_N = 1'b1;
    endtask

    task automatic test_glitch();
        int np = 0;
        pat.delete();
        for (int len = 1; len <= 3; len++) begin
            repeat (len) pat.push_back(1'b1);
            repeat (5) pat.push_back(1'b0);
        end
        repeat (12) pat.push_back(1'b0);
        foreach (pat[i]) begin
            @(negedge CLK);
            checks++;
            if (MODE !== exp_mode || PRESS !== exp_press || LED !== exp_led) begin
                failures++;
                $display("FAIL glitch_model t=%0t MODE=%0d/%0d PRESS=%b/%b LED=%b/%b",
                         $time, MODE, exp_mode, PRESS, exp_press, LED, exp_led);
            end
            if (PRESS === 1'b1) np++;
            BTN = pat[i];
        end
        checks++;
        if (np != 0) begin failures++; $display("FAIL glitch_press got=%0d exp=0", np); end
        checks++;
        if (MODE !== 2'd0) begin failures++; $display("FAIL glitch_mode got=%0d exp=0", MODE); end
    endtask

    task automatic test_short_press();
        int lat = -1;
        int np = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            checks++;
            if (MODE !== exp_mode || PRESS !== exp_press || LED !== exp_led) begin
                failures++;
                $display("FAIL short_model t=%0t MODE=%0d/%0d PRESS=%b/%b LED=%b/%b",
                         $time, MODE, exp_mode, PRESS, exp_press, LED, exp_led);
            end
            if (PRESS === 1'b1) np++;
            if (i > 10 && lat < 0 && MODE !== 2'd0) lat = i - 10;
            BTN = (i < 10);
        end
        checks++;
        if (lat != int'(DEB + 3)) begin failures++; $display("FAIL short_latency got=%0d exp=%0d", lat, DEB + 3); end
        checks++;
        if (np != 1) begin failures++; $display("FAIL short_press_count got=%0d exp=1", np); end
        checks++;
        if (MODE !== 2'd1 || LED !== 1'b1) begin
            failures++; $display("FAIL short_final MODE=%0d LED=%b exp MODE=1 LED=1", MODE, LED);
        end
    endtask

    task automatic test_four_presses();
        logic [1:0] prev;
        logic [1:0] seq[$];
        int since = 0;
        @(negedge CLK);
        RESET_N = 1'b0;
        BTN = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        prev = 2'd0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 46; i++) begin
                @(negedge CLK);
                checks++;
                if (MODE !== exp_mode || PRESS !== exp_press || LED !== exp_led) begin
                    failures++;
                    $display("FAIL four_model t=%0t MODE=%0d/%0d PRESS=%b/%b LED=%b/%b",
                             $time, MODE, exp_mode, PRESS, exp_press, LED, exp_led);
                end
                if (MODE !== prev) begin
                    seq.push_back(MODE);
                    prev = MODE;
                    since = 0;
                end else begin
                    since++;
                end
                if (MODE === 2'd2 && since >= 1 && since <= 16) begin
                    checks++;
                    if (LED !== 1'(since <= 8)) begin
                        failures++; $display("FAIL slow_blink j=%0d got=%b exp=%b", since, LED, since <= 8);
                    end
                end
                if (MODE === 2'd3 && since >= 1 && since <= 8) begin
                    checks++;
                    if (LED !== 1'(((since - 1) / 2) % 2 == 0)) begin
                        failures++; $display("FAIL fast_blink j=%0d got=%b", since, LED);
                    end
                end
                BTN = (i < 6);
            end
        end
        checks++;
        if (seq.size() != 4) begin
            failures++; $display("FAIL four_seq_len got=%0d exp=4", seq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (seq[k] !== 2'(k + 1)) begin
                    failures++; $display("FAIL four_seq k=%0d got=%0d exp=%0d", k, seq[k], 2'(k + 1));
                end
            end
        end
        checks++;
        if (MODE !== 2'd0 || LED !== 1'b0) begin
            failures++; $display("FAIL four_final MODE=%0d LED=%b exp 0/0", MODE, LED);
        end
    endtask

    task automatic test_long_press();
        int np = 0;
        pat.delete();
        repeat (2) begin
            repeat (6) pat.push_back(1'b1);
            repeat (20) pat.push_back(1'b0);
        end
        repeat (40) pat.push_back(1'b1);
        repeat (30) pat.push_back(1'b0);
        foreach (pat[i]) begin
            @(negedge CLK);
            checks++;
            if (MODE !== exp_mode || PRESS !== exp_press || LED !== exp_led) begin
                failures++;
                $display("FAIL long_model t=%0t MODE=%0d/%0d PRESS=%b/%b LED=%b/%b",
                         $time, MODE, exp_mode, PRESS, exp_press, LED, exp_led);
            end
            if (i == 52) begin
                checks++;
                if (MODE !== 2'd2) begin failures++; $display("FAIL long_setup got=%0d exp=2", MODE); end
            end
            if (i > 52 && PRESS === 1'b1) np++;
            BTN = pat[i];
        end
        checks++;
        if (np != 1) begin failures++; $display("FAIL long_press_count got=%0d exp=1", np); end
        checks++;
        if (MODE !== (LP_EN ? 2'd0 : 2'd3)) begin
            failures++; $display("FAIL long_mode got=%0d exp=%0d", MODE, LP_EN ? 0 : 3);
        end
    endtask

    task automatic test_reset_mid_blink();
        int np = 0;
        bit lit = 0;
        for (int p = 0; p < 4 && exp_mode < 2'd2; p++) begin
            for (int i = 0; i < 26; i++) begin
                @(negedge CLK);
                BTN = (i < 6);
            end
        end
        BTN = 1'b1;
        for (int i = 0; i < 20 && !lit; i++) begin
            @(negedge CLK);
            checks++;
            if (MODE !== exp_mode || PRESS !== exp_press || LED !== exp_led) begin
                failures++;
                $display("FAIL blink_model t=%0t MODE=%0d/%0d PRESS=%b/%b LED=%b/%b",
                         $time, MODE, exp_mode, PRESS, exp_press, LED, exp_led);
            end
            if (LED === 1'b1 && MODE >= 2'd2) lit = 1;
        end
        checks++;
        if (!lit) begin failures++; $display("FAIL blink_setup got=LED%b MODE%0d exp lit blink", LED, MODE); end
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if (LED !== 1'b0 || MODE !== 2'd0 || PRESS !== 1'b0) begin
            failures++; $display("FAIL async_reset LED=%b MODE=%0d PRESS=%b exp 0/0/0", LED, MODE, PRESS);
        end
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 42; i++) begin
            @(negedge CLK);
            checks++;
            if (MODE !== exp_mode || PRESS !== exp_press || LED !== exp_led) begin
                failures++;
                $display("FAIL post_reset_model t=%0t MODE=%0d/%0d PRESS=%b/%b LED=%b/%b",
                         $time, MODE, exp_mode, PRESS, exp_press, LED, exp_led);
            end
            if (PRESS === 1'b1) np++;
            BTN = (i < 12);
        end
        checks++;
        if (np != 1) begin failures++; $display("FAIL post_reset_press got=%0d exp=1", np); end
        checks++;
        if (MODE !== 2'd1) begin failures++; $display("FAIL post_reset_mode got=%0d exp=1", MODE); end
    endtask

    task automatic test_bounce();
        int np = 0;
        logic [1:0] want;
        want = exp_mode + 2'd1;
        pat.delete();
        repeat (8) pat.push_back(1'b1);
        pat.push_back(1'b0); pat.push_back(1'b1); pat.push_back(1'b0);
        repeat (20) pat.push_back(1'b0);
        foreach (pat[i]) begin
            @(negedge CLK);
            checks++;
            if (MODE !== exp_mode || PRESS !== exp_press || LED !== exp_led) begin
                failures++;
                $display("FAIL bounce_model t=%0t MODE=%0d/%0d PRESS=%b/%b LED=%b/%b",
                         $time, MODE, exp_mode, PRESS, exp_press, LED, exp_led);
            end
            if (PRESS === 1'b1) np++;
            BTN = pat[i];
        end
        checks++;
        if (np != 1) begin failures++; $display("FAIL bounce_press got=%0d exp=1", np); end
        checks++;
        if (MODE !== want) begin failures++; $display("FAIL bounce_mode got=%0d exp=%0d", MODE, want); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            int unsigned len;
            int unsigned gap;
            int unsigned bnc;
            len = $urandom_range(30, 1);
            gap = $urandom_range(25, 10);
            bnc = $urandom_range(1, 0);
            pat.delete();
            repeat (len) pat.push_back(1'b1);
            if (bnc != 0) begin
                pat.push_back(1'b0); pat.push_back(1'b1); pat.push_back(1'b0);
            end
            repeat (gap) pat.push_back(1'b0);
            foreach (pat[i]) begin
                @(negedge CLK);
                checks++;
                if (MODE !== exp_mode || PRESS !== exp_press || LED !== exp_led) begin
                    failures++;
                    $display("FAIL random_model t=%0t len=%0d MODE=%0d/%0d PRESS=%b/%b LED=%b/%b",
                             $time, len, MODE, exp_mode, PRESS, exp_press, LED, exp_led);
                end
                BTN = pat[i];
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_short_press();
        test_four_presses();
        test_long_press();
        test_reset_mid_blink();
        test_bounce();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_led_ctrl.md
BTN_LED_CTRL -- requirements
Module: btn_led_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 160000, debounce qualification time in clocks (10 ms at 16 MHz); legal range 1 to 2^20-1.
REQ-002 Parameter LONG_CYCLES, default 8000000, long-press threshold in clocks (0.5 s); legal range 1 to 2^24-1.
REQ-003 Parameter SLOW_HALF, default 4000000, half-period of slow blink in clocks.
REQ-004 Parameter FAST_HALF, default 1000000, half-period of fast blink in clocks.
REQ-005 CLK  input  1  system clock; all state is on the rising edge.
REQ-006 RESET_N  input  1  asynchronous active-low reset.
REQ-007 BTN  input  1  raw pushbutton: high = pressed (external pulldown), asynchronous to CLK.
REQ-008 LED  output  1  LED drive, high = lit, registered.
REQ-009 MODE  output  2  current mode: 0 OFF, 1 ON, 2 SLOW, 3 FAST, registered.
REQ-010 PRESS  output  1  one-cycle pulse per accepted button release.

Function
REQ-011 BTN shall pass through a two-flop synchronizer; the second flop output is the sampled button s.
REQ-012 The debouncer shall hold stable state d; a counter increments each cycle s != d and clears each cycle s == d.
REQ-013 When the counter equals DEB_CYCLES-1 and s != d, d shall take s on that edge and the counter shall clear; glitches shorter than DEB_CYCLES clocks shall never change d.
REQ-014 A hold counter shall count clocks while d = 1, saturating at LONG_CYCLES, and shall clear while d = 0.
REQ-015 Events shall be taken on the falling edge of d (release), never on press.
REQ-016 On release with hold count < LONG_CYCLES (short press), MODE shall advance OFF->ON->SLOW->FAST->OFF (wraps).
REQ-017 On release with hold count = LONG_CYCLES (long press), behaviour follows REQ-028/REQ-029.
REQ-018 MODE and PRESS shall update on the edge after d falls: total latency from the first clock sampling BTN low to MODE change is DEB_CYCLES+3 edges.
REQ-019 PRESS shall be high for exactly one cycle per accepted release, including releases that leave MODE unchanged.
REQ-020 LED: OFF -> 0; ON -> 1; SLOW/FAST -> square wave toggling every SLOW_HALF/FAST_HALF clocks.
REQ-021 On any MODE change, the blink phase counter shall clear and LED shall be 1 on the first cycle of SLOW/FAST, so the first lit half-period is full length.
REQ-022 LED shall be registered, changing one edge after the MODE/phase condition that selects it.
REQ-023 BTN held continuously shall generate no event until release, regardless of duration.

Reset
REQ-024 RESET_N low shall asynchronously force: sync flops 0, d 0, all counters 0, MODE 0 (OFF), LED 0, PRESS 0.
REQ-025 Deassertion is synchronized externally; the block shall resume on the first rising edge with RESET_N high.
REQ-026 Reset asserted mid-press shall discard the press; if BTN is still high after reset, d rises after DEB_CYCLES and the later release is a normal event measured from that rise.
REQ-027 Reset mid-blink shall drop LED to 0 immediately (asynchronously).

Configuration
REQ-028 With BTNLED_LONGPRESS_EN defined, a long press shall force MODE to OFF (from any mode, including OFF) and pulse PRESS.
REQ-029 Without BTNLED_LONGPRESS_EN, the hold counter shall not be implemented and every release shall be treated as a short press.

Verification (DEB_CYCLES=4, LONG_CYCLES=20, SLOW_HALF=8, FAST_HALF=2)
REQ-030 Reset, BTN high 10 clocks then low -> PRESS pulse once, MODE 0->1, LED 1 one edge later; MODE change exactly DEB_CYCLES+3 edges after BTN low sampled.
REQ-031 BTN high pulses of 1,2,3 clocks separated by 5 low clocks -> no PRESS, MODE stays 0.
REQ-032 Four short presses from reset -> MODE 1,2,3,0; in MODE 2 LED 1 for 8 clocks, 0 for 8; in MODE 3 period 4 clocks; final LED 0.
REQ-033 With BTNLED_LONGPRESS_EN: MODE 2, BTN high 40 clocks then low -> MODE 0, one PRESS; without the macro the same stimulus -> MODE 3.
REQ-034 RESET_N pulsed low mid-blink while BTN held high -> LED 0, MODE 0 immediately; after BTN low, one PRESS and MODE 1.
REQ-035 BTN bouncing (toggles every clock for 3 clocks) on release -> exactly one PRESS, MODE advances by one.
